seg7_scan_mux: RTL and testbench
================================

# seg7_scan_mux

Parametrised multi-digit 7-segment scan driver: holds up to DIGITS hex nibbles plus per-digit decimal points, time-multiplexes them onto one shared segment bus with one-hot digit enables, and inserts an anti-ghosting blank at each digit change. Adds double-buffered loading with optional frame-synchronous update, leading-zero suppression, global blanking and a frame-done strobe. Sits between the CPU debug/IO register file and the board's common-anode display.

## Interface
- DIGITS, 8: number of digits, 1..8; digit DIGITS-1 is most significant.
- SCAN_DIV, 100000: clock cycles per digit slot, >= 2.
- BLANK_CYC, 2: cycles at slot start with all anodes off; 0 <= BLANK_CYC < SCAN_DIV.
- FRAME_SYNC, 1: 1 = loaded data takes effect at the next frame boundary; 0 = the cycle after load.
- clk  in  1  system clock; the only clock.
- rst_n  in  1  asynchronous, active-low reset.
- data  in  4*DIGITS  hex nibbles; nibble i = data[4i+3:4i].
- points  in  DIGITS  decimal point per digit, active high.
- load  in  1  capture data/points when high at a rising edge.
- lzs  in  1  leading-zero suppression enable (level).
- blank  in  1  force display dark (level).
- seg  out  7  {a,b,c,d,e,f,g}, active low.
- dp  out  1  decimal point, active low.
- an  out  DIGITS  digit enables, active low, at most one low.
- frame_done  out  1  one-cycle pulse at end of last digit slot.

## Operation
- Registers: prescaler cnt (0..SCAN_DIV-1), digit index idx (0..DIGITS-1), shadow buffer (displayed), pending buffer + pend_valid (FRAME_SYNC=1 only).
- cnt increments every cycle; at SCAN_DIV-1 wraps to 0 and idx advances; idx wraps DIGITS-1 -> 0. Frame boundary = cnt==SCAN_DIV-1 and idx==DIGITS-1; frame_done asserted for that cycle's following output cycle.
- Load, FRAME_SYNC=0: shadow <= {data, points} on load edge.
- Load, FRAME_SYNC=1: pending <= {data, points}, pend_valid <= 1; at frame boundary, if pend_valid, shadow <= pending, pend_valid <= 0. Load coinciding with frame boundary: incoming data written directly to shadow, pend_valid cleared. Repeated loads before boundary: last wins.
- Decode (active-high a..g, driven inverted): 0=7E 1=30 2=6D 3=79 4=33 5=5B 6=5F 7=70 8=7F 9=7B A=77 b=1F C=4E d=3D E=4F F=47.
- Leading-zero suppression: with lzs=1, digit i>0 is suppressed if nibbles i..DIGITS-1 are all 0 and points i..DIGITS-1 are all 0. Digit 0 never suppressed. Suppressed digit: seg=7'h7F, dp=1, its anode still driven.
- Anode for idx driven low only when cnt >= BLANK_CYC and blank==0; otherwise an all ones. seg/dp follow the current idx regardless of blanking window.
- blank does not stop counters or loads.
- Reset (async assert, sync release): cnt=0, idx=0, shadow=0, pending=0, pend_valid=0, an=all ones, seg=7'h7F, dp=1, frame_done=0.

## Timing
- All outputs registered; output reflects state (cnt, idx, shadow, lzs, blank) with 1-cycle latency.
- FRAME_SYNC=0: load at edge k -> shadow valid after k -> visible on seg at edge k+1.
- First post-reset slot: digit 0, anodes off for cycles 0..BLANK_CYC-1 of output, on thereafter.
- Frame period = DIGITS*SCAN_DIV cycles; frame_done period identical, width 1.
- rst_n asserted mid-frame: outputs dark immediately (asynchronous), pending load discarded.

## Test plan
- DIGITS=4, SCAN_DIV=4, BLANK_CYC=1, FRAME_SYNC=0; load data=16'h12AF, points=0 -> idx0 slot seg=~47 (F), idx3 slot seg=~30 (1); an sequence 1111,1110,1110,1110,1111,1101,...; frame_done every 16 cycles.
- Same, lzs=1, data=16'h0050 -> digit3 seg=7F, digit2 seg=7F, digit1 seg=~5B, digit0 seg=~7E; set points[3]=1 -> digit3 shows ~7E with dp=0, digit2 shows ~7E.
- FRAME_SYNC=1: load 16'h1111 mid-frame then 16'h2222 -> display stays old until boundary, then shows 2222 from next digit 0 slot.
- FRAME_SYNC=1: load exactly on frame boundary with 16'h3333 -> first digit-0 slot of new frame shows 3.
- blank=1 for 10 cycles mid-frame -> an=1111 throughout, idx/frame_done timing unchanged after release.
- rst_n low mid-slot -> same cycle an=1111, seg=7F, dp=1, frame_done=0; after release scan restarts at digit 0, shadow=0 (displays 0000).

Source files
------------

// File: rtl/seg7_scan_mux.sv
// Multi-digit 7-segment scan driver for a common-anode display: double-buffered
// hex/point storage, anti-ghosting blank per slot, leading-zero suppression.
module seg7_scan_mux #(
    parameter int unsigned DIGITS     = 8,
    parameter int unsigned SCAN_DIV   = 100000,
    parameter int unsigned BLANK_CYC  = 2,
    parameter int unsigned FRAME_SYNC = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   i_data,
    input  logic [DIGITS-1:0]     i_points,
    input  logic                  i_load,
    input  logic                  i_lzs,
    input  logic                  i_blank,
    output logic [6:0]            o_seg,
    output logic                  o_dp,
    output logic [DIGITS-1:0]     o_an,
    output logic                  o_frame_done
);

    localparam int unsigned CW = $clog2(SCAN_DIV);
    localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] CNT_MAX   = CW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_MAX   = IW'(DIGITS - 1);
    localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYC);

    logic [CW-1:0]          r_cnt;
    logic [IW-1:0]          r_idx;
    logic [4*DIGITS-1:0]    r_shadow_data;
    logic [DIGITS-1:0]      r_shadow_pts;

    logic                   w_boundary;
    logic [3:0]             w_nib;
    logic                   w_pt;
    logic                   w_zero_up;
    logic                   w_suppress;
    logic [DIGITS-1:0]      w_an;

    function automatic logic [6:0] seg7_decode(input logic [3:0] nib);
        logic [6:0] segs;
        case (nib)
            4'h0: segs = 7'h7E;
            4'h1: segs = 7'h30;
            4'h2: segs = 7'h6D;
            4'h3: segs = 7'h79;
            4'h4: segs = 7'h33;
            4'h5: segs = 7'h5B;
            4'h6: segs = 7'h5F;
            4'h7: segs = 7'h70;
            4'h8: segs = 7'h7F;
            4'h9: segs = 7'h7B;
            4'hA: segs = 7'h77;
            4'hB: segs = 7'h1F;
            4'hC: segs = 7'h4E;
            4'hD: segs = 7'h3D;
            4'hE: segs = 7'h4F;
            default: segs = 7'h47;
        endcase
        return segs;
    endfunction

    assign w_boundary = (r_cnt == CNT_MAX) && (r_idx == IDX_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else if (r_cnt == CNT_MAX) begin
            r_cnt <= '0;
            r_idx <= (r_idx == IDX_MAX) ? '0 : r_idx + 1'b1;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    if (FRAME_SYNC != 0) begin : g_sync
        logic [4*DIGITS-1:0] r_pend_data;
        logic [DIGITS-1:0]   r_pend_pts;
        logic                r_pend_valid;

        // A load landing on the boundary bypasses the pending buffer entirely.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_shadow_data <= '0;
                r_shadow_pts  <= '0;
                r_pend_data   <= '0;
                r_pend_pts    <= '0;
                r_pend_valid  <= 1'b0;
            end else if (i_load && w_boundary) begin
                r_shadow_data <= i_data;
                r_shadow_pts  <= i_points;
                r_pend_valid  <= 1'b0;
            end else if (w_boundary && r_pend_valid) begin
                r_shadow_data <= r_pend_data;
                r_shadow_pts  <= r_pend_pts;
                r_pend_valid  <= 1'b0;
            end else if (i_load) begin
                r_pend_data   <= i_data;
                r_pend_pts    <= i_points;
                r_pend_valid  <= 1'b1;
            end
        end
    end else begin : g_direct
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_shadow_data <= '0;
                r_shadow_pts  <= '0;
            end else if (i_load) begin
                r_shadow_data <= i_data;
                r_shadow_pts  <= i_points;
            end
        end
    end

    always_comb begin
        w_nib     = '0;
        w_pt      = 1'b0;
        w_zero_up = 1'b1;
        w_an      = '1;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_idx == IW'(i)) begin
                w_nib = r_shadow_data[4*i +: 4];
                w_pt  = r_shadow_pts[i];
            end
            if ((IW'(i) >= r_idx) && ((r_shadow_data[4*i +: 4] != 4'h0) || r_shadow_pts[i])) begin
                w_zero_up = 1'b0;
            end
        end
        w_suppress = i_lzs && (r_idx != '0) && w_zero_up;
        if (!i_blank && (r_cnt >= BLANK_END)) begin
            for (int i = 0; i < DIGITS; i++) begin
                if (r_idx == IW'(i)) w_an[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_seg        <= 7'h7F;
            o_dp         <= 1'b1;
            o_an         <= '1;
            o_frame_done <= 1'b0;
        end else begin
            o_seg        <= w_suppress ? 7'h7F : ~seg7_decode(w_nib);
            o_dp         <= w_suppress ? 1'b1 : ~w_pt;
            o_an         <= w_an;
            o_frame_done <= w_boundary;
        end
    end

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Bench for seg7_scan_mux: one immediate-load and one frame-synchronous instance,
// both checked every cycle against a frame-position reference model.
module tb_seg7_scan_mux;

    localparam int D     = 4;
    localparam int S     = 4;
    localparam int B     = 1;
    localparam int FRAME = D * S;

    logic        clk;
    logic        rst_n;
    logic [15:0] data;
    logic [3:0]  points;
    logic        load;
    logic        lzs;
    logic        blank;

    logic [6:0]  seg0, seg1;
    logic        dp0, dp1;
    logic [3:0]  an0, an1;
    logic        fd0, fd1;

    int n_checks;
    int n_errors;

    // Model state: frame position counter plus per-instance shadow/pending copies.
    int          m_t;
    logic [15:0] m_sh_d [2];
    logic [3:0]  m_sh_p [2];
    logic [15:0] m_pd_d;
    logic [3:0]  m_pd_p;
    logic        m_pv;

    logic [6:0] dec_tbl [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                 7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

    seg7_scan_mux #(.DIGITS(D), .SCAN_DIV(S), .BLANK_CYC(B), .FRAME_SYNC(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .i_data(data), .i_points(points), .i_load(load),
        .i_lzs(lzs), .i_blank(blank), .o_seg(seg0), .o_dp(dp0), .o_an(an0),
        .o_frame_done(fd0)
    );

    seg7_scan_mux #(.DIGITS(D), .SCAN_DIV(S), .BLANK_CYC(B), .FRAME_SYNC(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .i_data(data), .i_points(points), .i_load(load),
        .i_lzs(lzs), .i_blank(blank), .o_seg(seg1), .o_dp(dp1), .o_an(an1),
        .o_frame_done(fd1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s t=%0t got=%0h expected=%0h", tag, $time, got, exp);
        end
    endtask

    // Digit is blank when lzs is on and it sits above the most significant
    // non-zero nibble or set point; digit 0 therefore always shows.
    function automatic void exp_digit(input logic [15:0] d, input logic [3:0] p, input int idx,
                                      input logic z, output logic [6:0] s, output logic dpo);
        int msd = 0;
        for (int i = 0; i < D; i++) begin
            logic [3:0] nb = d[4*i +: 4];
            if (nb != 4'h0 || p[i]) msd = i;
        end
        if (z && idx > msd) begin
            s   = 7'h7F;
            dpo = 1'b1;
        end else begin
            logic [3:0] nb = d[4*idx +: 4];
            s   = ~dec_tbl[nb];
            dpo = ~p[idx];
        end
    endfunction

    task automatic model_reset();
        m_t = 0;
        m_sh_d[0] = '0; m_sh_p[0] = '0;
        m_sh_d[1] = '0; m_sh_p[1] = '0;
        m_pd_d = '0; m_pd_p = '0; m_pv = 1'b0;
    endtask

    task automatic check_dark(input string tag);
        check({tag, "_an0"}, 32'(an0), 32'hF);
        check({tag, "_seg0"}, 32'(seg0), 32'h7F);
        check({tag, "_dp0"}, 32'(dp0), 32'h1);
        check({tag, "_fd0"}, 32'(fd0), 32'h0);
        check({tag, "_an1"}, 32'(an1), 32'hF);
        check({tag, "_seg1"}, 32'(seg1), 32'h7F);
        check({tag, "_fd1"}, 32'(fd1), 32'h0);
    endtask

    // One clock: predict outputs from pre-edge model state, advance model, compare.
    task automatic step();
        int         pos = m_t % FRAME;
        int         idx = pos / S;
        int         cnt = pos % S;
        logic [3:0] e_an;
        logic [3:0] one;
        logic       e_fd;
        logic [6:0] e_seg0, e_seg1;
        logic       e_dp0, e_dp1;
        logic       bnd = (pos == FRAME - 1);

        one  = 4'b0001 << idx;
        e_an = (blank || cnt < B) ? 4'hF : ~one;
        e_fd = bnd;
        exp_digit(m_sh_d[0], m_sh_p[0], idx, lzs, e_seg0, e_dp0);
        exp_digit(m_sh_d[1], m_sh_p[1], idx, lzs, e_seg1, e_dp1);

        if (load) begin
            m_sh_d[0] = data;
            m_sh_p[0] = points;
        end
        if (load && bnd) begin
            m_sh_d[1] = data; m_sh_p[1] = points; m_pv = 1'b0;
        end else if (bnd && m_pv) begin
            m_sh_d[1] = m_pd_d; m_sh_p[1] = m_pd_p; m_pv = 1'b0;
        end else if (load) begin
            m_pd_d = data; m_pd_p = points; m_pv = 1'b1;
        end
        m_t++;

        @(posedge clk);
        #1;
        check("an0", 32'(an0), 32'(e_an));
        check("seg0", 32'(seg0), 32'(e_seg0));
        check("dp0", 32'(dp0), 32'(e_dp0));
        check("fd0", 32'(fd0), 32'(e_fd));
        check("an1", 32'(an1), 32'(e_an));
        check("seg1", 32'(seg1), 32'(e_seg1));
        check("dp1", 32'(dp1), 32'(e_dp1));
        check("fd1", 32'(fd1), 32'(e_fd));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic run_to(input int p);
        for (int i = 0; i < FRAME && (m_t % FRAME) != p; i++) step();
    endtask

    task automatic load_once(input logic [15:0] d, input logic [3:0] p);
        data = d; points = p; load = 1'b1;
        step();
        load = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0; data = '0; points = '0; load = 1'b0; lzs = 1'b0; blank = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        check_dark("rst");
        #1 rst_n = 1'b1;

        run(2);
        load_once(16'h12AF, 4'h0);
        run(40);

        lzs = 1'b1;
        load_once(16'h0050, 4'h0);
        run(20);
        load_once(16'h0050, 4'h8);
        run(20);
        lzs = 1'b0;

        run_to(5);
        load_once(16'h1111, 4'h0);
        run_to(8);
        load_once(16'h2222, 4'h0);
        run(40);

        run_to(15);
        load_once(16'h3333, 4'h0);
        run(20);
        run_to(3);
        load_once(16'h4444, 4'h1);
        run_to(15);
        load_once(16'h5555, 4'h2);
        run(20);

        run_to(6);
        blank = 1'b1;
        run(10);
        blank = 1'b0;
        run(20);

        load_once(16'h9876, 4'h5);
        run_to(9);
        load_once(16'hABCD, 4'h0);
        #2 rst_n = 1'b0;
        #1;
        check_dark("async_rst");
        model_reset();
        @(posedge clk);
        #1;
        check_dark("rst_hold");
        #1 rst_n = 1'b1;
        run(40);

        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 15) == 0) begin
                for (int i = 0; i < D; i++) begin
                    data[4*i +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
                end
                points = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
                load = 1'b1;
            end else begin
                load = 1'b0;
            end
            if ($urandom_range(0, 49) == 0) lzs = ~lzs;
            if ($urandom_range(0, 29) == 0) blank = ~blank;
            step();
        end
        load = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
